// File: rtl/shift_buffer_layer_sequencer_pkg.sv
// rtl/shift_buffer_layer_sequencer_pkg.sv - shared widths, state encoding, config layout and kernel legality check
package shift_buffer_pkg;

    localparam int DATA_WIDTH           = 16;
    localparam int CONV_UNITS           = 8;
    localparam int KERNEL_H_MAX         = 3;
    localparam int CH_IN_COUNTER_WIDTH  = 10;
    localparam int BLOCKS_COUNTER_WIDTH = 10;

    localparam int CFG_W = BLOCKS_COUNTER_WIDTH + CH_IN_COUNTER_WIDTH + KERNEL_H_MAX;
    localparam int ROW_W = DATA_WIDTH * (CONV_UNITS + KERNEL_H_MAX - 1);

    localparam logic [KERNEL_H_MAX-1:0] KH_1_LIMIT = KERNEL_H_MAX'(KERNEL_H_MAX - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // S_CFG tdata layout, kernel_h_1 in the LSBs
    typedef struct packed {
        logic [BLOCKS_COUNTER_WIDTH-1:0] blocks_1;
        logic [CH_IN_COUNTER_WIDTH-1:0]  im_channels_in_1;
        logic [KERNEL_H_MAX-1:0]         kernel_h_1;
    } cfg_t;

    // Only odd kernel heights are supported, i.e. kernel_h-1 even and within range
    function automatic logic kernel_h_legal(input logic [KERNEL_H_MAX-1:0] kh_1);
        return !kh_1[0] && (kh_1 <= KH_1_LIMIT);
    endfunction

endpackage

// File: rtl/shift_buffer_layer_sequencer_if.sv
// rtl/shift_buffer_layer_sequencer_if.sv - stream bundle (tdata/tvalid/tready/tlast) with master, slave and monitor views
interface shift_buffer_layer_sequencer_if #(
    parameter int W = 8
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master  (output tdata, output tvalid, output tlast, input tready);
    modport slave   (input tdata, input tvalid, input tlast, output tready);
    modport monitor (input tdata, input tvalid, input tready, input tlast);
endinterface

// File: rtl/shift_buffer_layer_sequencer_wrap_counter.sv
// rtl/shift_buffer_layer_sequencer_wrap_counter.sv - enabled up-counter wrapping at a runtime max, sync clear, async reset
// Ports: aclk/aresetn, i_clr (sync clear), i_clken (advance), i_max (wrap value),
//        o_count (current value), o_at_max (count == max)
module shift_seq_wrap_counter #(
    parameter int W = 10
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         i_clr,
    input  logic         i_clken,
    input  logic [W-1:0] i_max,
    output logic [W-1:0] o_count,
    output logic         o_at_max
);
    logic [W-1:0] r_count;

    assign o_count  = r_count;
    assign o_at_max = (r_count == i_max);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_clken) begin
            r_count <= o_at_max ? '0 : r_count + 1'b1;
        end
    end
endmodule

// File: rtl/shift_buffer_layer_sequencer.sv
// rtl/shift_buffer_layer_sequencer.sv - per-layer sequencer feeding axis_shift_buffer
// Optional feature macro: SHIFT_SEQ_CFG_CHECK_EN (reject even kernel heights, sticky cfg_err)
// Ports: aclk/aresetn; S_CFG (slave, one config beat per layer); S_AXIS (slave, row beats in);
//        M_AXIS (master, row beats to buffer, zero-latency pass-through); OBS (monitor of the
//        buffer output, counts tlasts); kernel_h_1/im_channels_in_1 (stable layer config);
//        layer_done (1-cycle pulse), busy (not idle), cfg_err (sticky illegal config).
import shift_buffer_pkg::*;

module shift_buffer_layer_sequencer (
    input  logic                              aclk,
    input  logic                              aresetn,
    shift_buffer_layer_sequencer_if.slave     S_CFG,
    shift_buffer_layer_sequencer_if.slave     S_AXIS,
    shift_buffer_layer_sequencer_if.master    M_AXIS,
    shift_buffer_layer_sequencer_if.monitor   OBS,
    output logic [KERNEL_H_MAX-1:0]           kernel_h_1,
    output logic [CH_IN_COUNTER_WIDTH-1:0]    im_channels_in_1,
    output logic                              layer_done,
    output logic                              busy,
    output logic                              cfg_err
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]                      r_state;
    logic [1:0]                      w_next_state;
    logic [KERNEL_H_MAX-1:0]         r_kernel_h_1;
    logic [CH_IN_COUNTER_WIDTH-1:0]  r_ch_in_1;
    logic [BLOCKS_COUNTER_WIDTH-1:0] r_blocks_1;
    logic                            r_layer_done;

    cfg_t w_cfg;
    logic w_cfg_hs, w_cfg_ok, w_run;
    logic w_in_hs, w_tl_hs, w_last_beat, w_final_tl;
    logic w_ch_at_max, w_blk_at_max, w_tl_at_max;
    logic [CH_IN_COUNTER_WIDTH-1:0]  w_ch_cnt;
    logic [BLOCKS_COUNTER_WIDTH-1:0] w_blk_cnt, w_tl_cnt;
    logic w_unused;

    assign w_cfg    = S_CFG.tdata;
    assign w_run    = (r_state == ST_RUN);
    assign w_cfg_hs = S_CFG.tvalid && (r_state == ST_IDLE);

`ifdef SHIFT_SEQ_CFG_CHECK_EN
    assign w_cfg_ok = kernel_h_legal(w_cfg.kernel_h_1);
`else
    assign w_cfg_ok = 1'b1;
`endif

    assign S_CFG.tready  = (r_state == ST_IDLE);
    assign S_AXIS.tready = M_AXIS.tready && w_run;
    assign M_AXIS.tvalid = S_AXIS.tvalid && w_run;
    assign M_AXIS.tdata  = S_AXIS.tdata;
    assign M_AXIS.tlast  = S_AXIS.tlast;

    assign w_in_hs     = S_AXIS.tvalid && M_AXIS.tready && w_run;
    // tlasts from the buffer only belong to this layer once it has started
    assign w_tl_hs     = OBS.tvalid && OBS.tready && OBS.tlast && (r_state != ST_IDLE);
    assign w_last_beat = w_in_hs && w_ch_at_max && w_blk_at_max;
    assign w_final_tl  = w_tl_hs && w_tl_at_max;

    shift_seq_wrap_counter #(.W(CH_IN_COUNTER_WIDTH)) u_ch_cnt (
        .aclk(aclk), .aresetn(aresetn), .i_clr(w_cfg_hs), .i_clken(w_in_hs),
        .i_max(r_ch_in_1), .o_count(w_ch_cnt), .o_at_max(w_ch_at_max)
    );

    shift_seq_wrap_counter #(.W(BLOCKS_COUNTER_WIDTH)) u_blk_cnt (
        .aclk(aclk), .aresetn(aresetn), .i_clr(w_cfg_hs), .i_clken(w_in_hs && w_ch_at_max),
        .i_max(r_blocks_1), .o_count(w_blk_cnt), .o_at_max(w_blk_at_max)
    );

    shift_seq_wrap_counter #(.W(BLOCKS_COUNTER_WIDTH)) u_tl_cnt (
        .aclk(aclk), .aresetn(aresetn), .i_clr(w_cfg_hs), .i_clken(w_tl_hs),
        .i_max(r_blocks_1), .o_count(w_tl_cnt), .o_at_max(w_tl_at_max)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_cfg_hs && w_cfg_ok) w_next_state = ST_RUN;
            // The final tlast can land on the same cycle as the last input beat
            ST_RUN:   if (w_last_beat) w_next_state = w_final_tl ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (w_final_tl) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= ST_IDLE;
            r_kernel_h_1 <= '0;
            r_ch_in_1    <= '0;
            r_blocks_1   <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_layer_done <= (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
            if (w_cfg_hs && w_cfg_ok) begin
                r_kernel_h_1 <= w_cfg.kernel_h_1;
                r_ch_in_1    <= w_cfg.im_channels_in_1;
                r_blocks_1   <= w_cfg.blocks_1;
            end
        end
    end

`ifdef SHIFT_SEQ_CFG_CHECK_EN
    logic r_cfg_err;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cfg_err <= 1'b0;
        end else if (w_cfg_hs && !w_cfg_ok) begin
            r_cfg_err <= 1'b1;
        end
    end
    assign cfg_err = r_cfg_err;
`else
    assign cfg_err = 1'b0;
`endif

    assign kernel_h_1       = r_kernel_h_1;
    assign im_channels_in_1 = r_ch_in_1;
    assign layer_done       = r_layer_done;
    assign busy             = (r_state != ST_IDLE);

    assign w_unused = ^{S_CFG.tlast, OBS.tdata, w_ch_cnt, w_blk_cnt, w_tl_cnt};
endmodule

// File: tb/tb_shift_buffer_layer_sequencer.sv
// tb/tb_shift_buffer_layer_sequencer.sv - self-checking bench for shift_buffer_layer_sequencer
import shift_buffer_pkg::*;

module tb_shift_buffer_layer_sequencer;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    shift_buffer_layer_sequencer_if #(.W(CFG_W)) s_cfg ();
    shift_buffer_layer_sequencer_if #(.W(ROW_W)) s_axis ();
    shift_buffer_layer_sequencer_if #(.W(ROW_W)) m_axis ();
    shift_buffer_layer_sequencer_if #(.W(1))     obs ();

    logic [KERNEL_H_MAX-1:0]        kh;
    logic [CH_IN_COUNTER_WIDTH-1:0] ch;
    logic                           done, busy, err;

    shift_buffer_layer_sequencer dut (
        .aclk(aclk), .aresetn(aresetn),
        .S_CFG(s_cfg), .S_AXIS(s_axis), .M_AXIS(m_axis), .OBS(obs),
        .kernel_h_1(kh), .im_channels_in_1(ch),
        .layer_done(done), .busy(busy), .cfg_err(err)
    );

    localparam logic [CFG_W-1:0] CFG1  = {10'd1, 10'd2, 3'd2};
    localparam logic [CFG_W-1:0] CFG0  = {10'd0, 10'd0, 3'd0};
    localparam logic [CFG_W-1:0] CFGK2 = {10'd0, 10'd0, 3'd2};
    localparam logic [CFG_W-1:0] CFGK1 = {10'd0, 10'd0, 3'd1};

    typedef struct {
        logic                 cfg_v;
        logic [CFG_W-1:0]     cfg_d;
        logic                 s_v;
        logic                 m_r;
        logic                 obs_hs;
        logic                 e_cfg_r;
        logic                 e_s_r;
        logic                 e_m_v;
        logic                 e_busy;
        logic                 e_done;
        logic [2:0]           e_kh;
        logic [9:0]           e_ch;
    } vec_t;

    vec_t tbl [14];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_d(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [CFG_W-1:0] cd, input logic sv,
                         input logic mr, input logic oh);
        s_cfg.tvalid   = cv;
        s_cfg.tdata    = cd;
        s_axis.tvalid  = sv;
        m_axis.tready  = mr;
        obs.tvalid     = oh;
        obs.tready     = oh;
        obs.tlast      = oh;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int                idx;
        logic [ROW_W-1:0]  exp_d;
        logic              mr;

        // Test 1 / 3 / 4 as a per-cycle table; registered outputs reflect the previous edge
        //                 cfg_v cfg_d  s_v   m_r   obs    cfg_r s_r   m_v   busy  done  kh    ch
        tbl[0]  = '{1'b1, CFG1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0};
        tbl[1]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[2]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[3]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[4]  = '{1'b0, CFG0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[5]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[6]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[7]  = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[8]  = '{1'b1, CFG0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[9]  = '{1'b1, CFG0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 10'd2};
        tbl[10] = '{1'b1, CFG0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 10'd2};
        tbl[11] = '{1'b0, CFG0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 10'd0};
        tbl[12] = '{1'b0, CFG0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 10'd0};
        tbl[13] = '{1'b0, CFG0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 10'd0};

        drive(1'b0, CFG0, 1'b0, 1'b0, 1'b0);
        s_cfg.tlast  = 1'b0;
        s_axis.tlast = 1'b0;
        s_axis.tdata = '0;
        obs.tdata    = 1'b0;

        // Reset state while held in reset
        repeat (2) @(negedge aclk);
        #1;
        chk_b("rst_cfg_rdy", s_cfg.tready, 1'b1);
        chk_b("rst_s_rdy", s_axis.tready, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_err", err, 1'b0);
        chk_v("rst_kh", 32'(kh), 32'd0);
        chk_v("rst_ch", 32'(ch), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge aclk);
            drive(tbl[i].cfg_v, tbl[i].cfg_d, tbl[i].s_v, tbl[i].m_r, tbl[i].obs_hs);
            s_axis.tdata = {10{16'(i + 1)}};
            exp_d        = {10{16'(i + 1)}};
            #1;
            chk_b($sformatf("v%0d_cfg_rdy", i), s_cfg.tready, tbl[i].e_cfg_r);
            chk_b($sformatf("v%0d_s_rdy", i), s_axis.tready, tbl[i].e_s_r);
            chk_b($sformatf("v%0d_m_vld", i), m_axis.tvalid, tbl[i].e_m_v);
            chk_b($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk_b($sformatf("v%0d_done", i), done, tbl[i].e_done);
            chk_v($sformatf("v%0d_kh", i), 32'(kh), 32'(tbl[i].e_kh));
            chk_v($sformatf("v%0d_ch", i), 32'(ch), 32'(tbl[i].e_ch));
            chk_d($sformatf("v%0d_data", i), m_axis.tdata, exp_d);
        end

        // Test 2: random downstream backpressure
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b1, 1'b1, 1'b0);
        #1;
        chk_b("t2_idle_no_accept", s_axis.tready, 1'b0);
        chk_b("t2_idle_no_mvalid", m_axis.tvalid, 1'b0);
        @(negedge aclk);
        drive(1'b1, CFG1, 1'b0, 1'b0, 1'b0);
        idx = 0;
        for (int c = 0; c < 300 && idx < 6; c++) begin
            @(negedge aclk);
            mr = 1'($urandom_range(0, 1));
            drive(1'b0, CFG0, 1'b1, mr, 1'b0);
            s_axis.tdata = {10{16'(16'h100 + idx)}};
            #1;
            if (m_axis.tvalid && mr) begin
                chk_b($sformatf("t2_s_rdy_%0d", c), s_axis.tready, 1'b1);
                exp_d = {10{16'(16'h100 + idx)}};
                chk_d($sformatf("t2_data_%0d", idx), m_axis.tdata, exp_d);
                idx++;
            end
        end
        chk_v("t2_beats_accepted", 32'(idx), 32'd6);
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            drive(1'b0, CFG0, 1'b1, 1'b1, 1'b0);
            #1;
            chk_b($sformatf("t2_drain_no_accept_%0d", c), s_axis.tready, 1'b0);
            chk_b($sformatf("t2_drain_busy_%0d", c), busy, 1'b1);
        end
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b1);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b1);
        #1;
        chk_b("t2_done_early", done, 1'b0);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_b("t2_done", done, 1'b1);
        chk_b("t2_idle", busy, 1'b0);
        @(negedge aclk);
        #1;
        chk_b("t2_done_pulse", done, 1'b0);

        // Test 5: reset mid-RUN after 3 beats
        @(negedge aclk);
        drive(1'b1, CFG1, 1'b0, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            drive(1'b0, CFG0, 1'b1, 1'b1, 1'b0);
        end
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk_b("t5_busy", busy, 1'b0);
        chk_b("t5_done", done, 1'b0);
        chk_v("t5_kh", 32'(kh), 32'd0);
        chk_v("t5_ch", 32'(ch), 32'd0);
        chk_b("t5_s_rdy", s_axis.tready, 1'b0);
        chk_b("t5_cfg_rdy", s_cfg.tready, 1'b1);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            drive(1'b0, CFG0, 1'b1, 1'b1, 1'b1);
            #1;
            chk_b($sformatf("t5_no_done_%0d", c), done, 1'b0);
            chk_b($sformatf("t5_no_accept_%0d", c), s_axis.tready, 1'b0);
        end
        @(negedge aclk);
        drive(1'b1, CFGK2, 1'b0, 1'b1, 1'b0);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b1, 1'b1, 1'b1);
        #1;
        chk_v("t5_fresh_kh", 32'(kh), 32'd2);
        chk_b("t5_fresh_busy", busy, 1'b1);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_b("t5_fresh_done", done, 1'b1);

        // Test 6: even kernel height
        @(negedge aclk);
        drive(1'b1, CFGK1, 1'b0, 1'b1, 1'b0);
        #1;
        chk_b("t6_cfg_rdy", s_cfg.tready, 1'b1);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b0);
        #1;
`ifdef SHIFT_SEQ_CFG_CHECK_EN
        chk_b("t6_err", err, 1'b1);
        chk_b("t6_busy", busy, 1'b0);
        chk_v("t6_kh_kept", 32'(kh), 32'd2);
        @(negedge aclk);
        #1;
        chk_b("t6_err_sticky", err, 1'b1);
`else
        chk_b("t6_err", err, 1'b0);
        chk_b("t6_busy", busy, 1'b1);
        chk_v("t6_kh", 32'(kh), 32'd1);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b1, 1'b1, 1'b1);
        @(negedge aclk);
        drive(1'b0, CFG0, 1'b0, 1'b1, 1'b0);
        #1;
        chk_b("t6_done", done, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
